// File: rtl/sine_sched_pkg.sv
// Shared types and constants for the sine sample scheduler.
package sine_sched_pkg;

   localparam int THETA_W = 8;
   localparam int SINE_W  = 9;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADV    = 3'd1,
      S_ADDR   = 3'd2,
      S_CAP    = 3'd3,
      S_COMMIT = 3'd4
   } state_t;

   localparam state_t              RST_STATE   = S_IDLE;
   localparam logic [THETA_W-1:0]  RST_THETA   = '0;
   localparam logic [SINE_W-1:0]   RST_SINE    = '0;
   localparam logic                RST_VALID   = 1'b0;
   localparam logic                RST_BUSY    = 1'b0;
   localparam logic                RST_OVERRUN = 1'b0;

endpackage

// File: rtl/sine_phase_acc.sv
// Shared phase accumulator; theta is its top byte, rounded to nearest when
// SINE_PWM_SCHED_ROUND_EN is defined, truncated otherwise.
module sine_phase_acc
   import sine_sched_pkg::*;
#(
   parameter int ACC_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               enable_i,
   input  logic               adv_i,
   input  logic [ACC_W-1:0]   freq_word_i,
   output logic [THETA_W-1:0] theta_o
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             unused_lsbs;

   always_comb begin
      acc_d = acc_q;
      if (!enable_i) begin
         acc_d = '0;
      end else if (adv_i) begin
         acc_d = acc_q + freq_word_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

`ifdef SINE_PWM_SCHED_ROUND_EN
   // Half-LSB carry wraps 255 -> 0 through the 8-bit add.
   assign theta_o = acc_q[ACC_W-1 -: THETA_W] + THETA_W'(acc_q[ACC_W-THETA_W-1]);
`else
   assign theta_o = acc_q[ACC_W-1 -: THETA_W];
`endif

   assign unused_lsbs = ^acc_q[ACC_W-THETA_W-1:0];

endmodule

// File: rtl/sine_pwm_sched.sv
// Per-period sine sample scheduler sharing one external LUT across NUM_CH
// phase-shifted channels. Build option: SINE_PWM_SCHED_ROUND_EN (theta rounding).
//
// state  | meaning
// IDLE   | waiting for a carrier period strobe
// ADV    | accumulator advanced by FREQ_WORD, channel index reset
// ADDR   | LUT address for current channel registered
// CAP    | LUT result captured into the channel shadow
// COMMIT | all shadows copied to SAMPLE_OUT, SAMPLE_VALID pulses
module sine_pwm_sched
   import sine_sched_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int ACC_W  = 16
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     ENABLE,
   input  logic                     PERIOD_STB,
   input  logic [ACC_W-1:0]         FREQ_WORD,
   input  logic [8*NUM_CH-1:0]      PHASE_OFS,
   output logic [THETA_W-1:0]       LUT_THETA,
   input  logic [SINE_W-1:0]        LUT_SINE,
   output logic [SINE_W*NUM_CH-1:0] SAMPLE_OUT,
   output logic                     SAMPLE_VALID,
   output logic                     BUSY,
   output logic                     OVERRUN
);

   localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

   state_t                     state_q;
   logic [CH_W-1:0]            ch_q;
   logic [THETA_W-1:0]         lut_theta_q;
   logic [SINE_W-1:0]          shadow_q [NUM_CH];
   logic [SINE_W*NUM_CH-1:0]   sample_out_q;
   logic                       valid_q;
   logic                       busy_q;
   logic                       overrun_q;
   logic [THETA_W-1:0]         theta;
   logic [THETA_W-1:0]         ofs [NUM_CH];
   logic                       adv;

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         ofs[k] = PHASE_OFS[8*k +: 8];
      end
   end

   assign adv = ENABLE && (state_q == S_ADV);

   sine_phase_acc #(
      .ACC_W (ACC_W)
   ) u_phase_acc (
      .clk_i       (CLK),
      .rst_n_i     (RST_N),
      .enable_i    (ENABLE),
      .adv_i       (adv),
      .freq_word_i (FREQ_WORD),
      .theta_o     (theta)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= RST_STATE;
         ch_q         <= '0;
         lut_theta_q  <= RST_THETA;
         for (int k = 0; k < NUM_CH; k++) begin
            shadow_q[k] <= RST_SINE;
         end
         sample_out_q <= '0;
         valid_q      <= RST_VALID;
         busy_q       <= RST_BUSY;
         overrun_q    <= RST_OVERRUN;
      end else begin
         valid_q   <= 1'b0;
         // A strobe arriving mid-scan is dropped, never queued.
         overrun_q <= PERIOD_STB && (state_q != S_IDLE);
         if (!ENABLE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (PERIOD_STB) begin
                     state_q <= S_ADV;
                     busy_q  <= 1'b1;
                  end
               end
               S_ADV: begin
                  ch_q    <= '0;
                  state_q <= S_ADDR;
               end
               S_ADDR: begin
                  lut_theta_q <= theta + ofs[ch_q];
                  state_q     <= S_CAP;
               end
               S_CAP: begin
                  shadow_q[ch_q] <= LUT_SINE;
                  if (ch_q == CH_LAST) begin
                     state_q <= S_COMMIT;
                  end else begin
                     ch_q    <= ch_q + 1'b1;
                     state_q <= S_ADDR;
                  end
               end
               S_COMMIT: begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     sample_out_q[SINE_W*k +: SINE_W] <= shadow_q[k];
                  end
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign LUT_THETA    = lut_theta_q;
   assign SAMPLE_OUT   = sample_out_q;
   assign SAMPLE_VALID = valid_q;
   assign BUSY         = busy_q;
   assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_sine_pwm_sched.sv
// Self-checking bench for sine_pwm_sched with an identity LUT stub.
module tb_sine_pwm_sched;

   localparam int N  = 3;
   localparam int AW = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           enable = 1'b0;
   logic           stb = 1'b0;
   logic [AW-1:0]  fw = '0;
   logic [8*N-1:0] ofs = '0;
   logic [7:0]     lut_theta;
   logic [8:0]     lut_sine;
   logic [9*N-1:0] sample_out;
   logic           sample_valid, busy, overrun;

   int             errors = 0;
   int             checks = 0;
   int             model_acc = 0;
   logic [9*N-1:0] exp_out = '0;

   assign lut_sine = {1'b0, lut_theta};

   always #5 clk = ~clk;

   sine_pwm_sched #(.NUM_CH(N), .ACC_W(AW)) dut (
      .CLK          (clk),
      .RST_N        (rst_n),
      .ENABLE       (enable),
      .PERIOD_STB   (stb),
      .FREQ_WORD    (fw),
      .PHASE_OFS    (ofs),
      .LUT_THETA    (lut_theta),
      .LUT_SINE     (lut_sine),
      .SAMPLE_OUT   (sample_out),
      .SAMPLE_VALID (sample_valid),
      .BUSY         (busy),
      .OVERRUN      (overrun)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int theta_of(input int acc);
`ifdef SINE_PWM_SCHED_ROUND_EN
      return ((acc / 256) + ((acc / 128) % 2)) % 256;
`else
      return (acc / 256) % 256;
`endif
   endfunction

   function automatic logic [9*N-1:0] exp_samples(input int th, input logic [8*N-1:0] o);
      logic [9*N-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) begin
         r[9*k +: 9] = 9'((th + int'(o[8*k +: 8])) % 256);
      end
      return r;
   endfunction

   task automatic clear_acc();
      enable = 1'b0;
      tick();
      enable = 1'b1;
      model_acc = 0;
   endtask

   // One full scan; chain=1 skips the trailing idle cycle so the next call's
   // strobe lands at the minimum legal spacing.
   task automatic do_scan(input logic [AW-1:0] f, input logic [8*N-1:0] o, input bit chain);
      logic [9*N-1:0] exp_new;
      int vcnt;
      int ovcnt;
      fw = f;
      ofs = o;
      stb = 1'b1;
      tick();
      stb = 1'b0;
      model_acc = (model_acc + int'(f)) % 65536;
      exp_new = exp_samples(theta_of(model_acc), o);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL scan_busy_hi: got %0b expected 1", busy);
      end
      vcnt = 0;
      ovcnt = 0;
      for (int n = 1; n <= 2*N+2; n++) begin
         tick();
         if (n < 2*N+2 && sample_valid) vcnt++;
         if (overrun) ovcnt++;
         for (int k = 0; k < N; k++) begin
            if (n == 2 + 2*k) begin
               checks++;
               if (lut_theta !== exp_new[9*k +: 8]) begin
                  errors++;
                  $display("FAIL lut_theta_ch%0d: got %0d expected %0d", k, lut_theta, exp_new[9*k +: 8]);
               end
            end
         end
         if (n == 2*N+1) begin
            checks++;
            if (sample_out !== exp_out) begin
               errors++;
               $display("FAIL sample_out_stable: got %0h expected %0h", sample_out, exp_out);
            end
         end
      end
      checks++;
      if (sample_valid !== 1'b1) begin
         errors++;
         $display("FAIL sample_valid_at_commit: got %0b expected 1", sample_valid);
      end
      checks++;
      if (sample_out !== exp_new) begin
         errors++;
         $display("FAIL sample_out: got %0h expected %0h", sample_out, exp_new);
      end
      checks++;
      if (vcnt !== 0) begin
         errors++;
         $display("FAIL early_valid: got %0d pulses expected 0", vcnt);
      end
      checks++;
      if (ovcnt !== 0) begin
         errors++;
         $display("FAIL spurious_overrun: got %0d pulses expected 0", ovcnt);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_after_commit: got %0b expected 0", busy);
      end
      exp_out = exp_new;
      if (!chain) begin
         tick();
         checks++;
         if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: got %0b expected 0", sample_valid);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b0;
      #2;
      checks++;
      if (lut_theta !== 8'd0) begin errors++; $display("FAIL rst_lut_theta: got %0d expected 0", lut_theta); end
      checks++;
      if (sample_out !== '0) begin errors++; $display("FAIL rst_sample_out: got %0h expected 0", sample_out); end
      checks++;
      if ({sample_valid, busy, overrun} !== 3'b000) begin
         errors++;
         $display("FAIL rst_flags: got %b expected 000", {sample_valid, busy, overrun});
      end
      tick();
      tick();
      rst_n = 1'b1;
      enable = 1'b1;
      tick();
      model_acc = 0;
      exp_out = '0;
   endtask

   task automatic test_single();
      do_scan(16'h0100, {8'd171, 8'd85, 8'd0}, 1'b0);
      checks++;
      if (sample_out !== {9'd172, 9'd86, 9'd1}) begin
         errors++;
         $display("FAIL single_literal: got %0h expected %0h", sample_out, {9'd172, 9'd86, 9'd1});
      end
   endtask

   task automatic test_wrap();
      int w0 [5] = '{64, 128, 192, 0, 64};
      int w2 [5] = '{235, 43, 107, 171, 235};
      clear_acc();
      for (int i = 0; i < 5; i++) begin
         do_scan(16'h4000, {8'd171, 8'd85, 8'd0}, 1'b0);
         checks++;
         if (int'(sample_out[8:0]) != w0[i] || int'(sample_out[26:18]) != w2[i]) begin
            errors++;
            $display("FAIL wrap_%0d: got ch0=%0d ch2=%0d expected ch0=%0d ch2=%0d",
                     i, sample_out[8:0], sample_out[26:18], w0[i], w2[i]);
         end
         tick();
         tick();
      end
   endtask

   task automatic test_overrun();
      logic [AW-1:0]  f;
      logic [8*N-1:0] o;
      logic [9*N-1:0] exp_new;
      int vcnt;
      f = AW'($urandom);
      o = (8*N)'($urandom);
      fw = f;
      ofs = o;
      stb = 1'b1;
      tick();
      stb = 1'b0;
      model_acc = (model_acc + int'(f)) % 65536;
      exp_new = exp_samples(theta_of(model_acc), o);
      vcnt = 0;
      for (int n = 1; n <= 10; n++) begin
         if (n == 4) stb = 1'b1;
         tick();
         stb = 1'b0;
         if (sample_valid) vcnt++;
         checks++;
         if (overrun !== (n == 4)) begin
            errors++;
            $display("FAIL overrun_n%0d: got %0b expected %0b", n, overrun, (n == 4));
         end
         if (n == 8) begin
            checks++;
            if (sample_out !== exp_new) begin
               errors++;
               $display("FAIL overrun_out: got %0h expected %0h", sample_out, exp_new);
            end
         end
      end
      checks++;
      if (vcnt !== 1) begin
         errors++;
         $display("FAIL overrun_valid_count: got %0d expected 1", vcnt);
      end
      exp_out = exp_new;
      do_scan(AW'($urandom), (8*N)'($urandom), 1'b0);
   endtask

   task automatic test_abort();
      int vcnt;
      fw = AW'($urandom);
      ofs = (8*N)'($urandom);
      stb = 1'b1;
      tick();
      stb = 1'b0;
      for (int n = 1; n <= 4; n++) tick();
      enable = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy: got %0b expected 0", busy);
      end
      enable = 1'b1;
      model_acc = 0;
      vcnt = 0;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (sample_valid) vcnt++;
      end
      checks++;
      if (vcnt !== 0) begin
         errors++;
         $display("FAIL abort_valid: got %0d pulses expected 0", vcnt);
      end
      checks++;
      if (sample_out !== exp_out) begin
         errors++;
         $display("FAIL abort_out_held: got %0h expected %0h", sample_out, exp_out);
      end
      do_scan(AW'($urandom), (8*N)'($urandom), 1'b0);
   endtask

   task automatic test_back_to_back();
      do_scan(AW'($urandom), (8*N)'($urandom), 1'b1);
      do_scan(AW'($urandom), (8*N)'($urandom), 1'b1);
      do_scan(AW'($urandom), (8*N)'($urandom), 1'b0);
   endtask

   task automatic test_async_reset();
      logic [AW-1:0] f2;
      int exp0;
      fw = AW'($urandom);
      ofs = (8*N)'($urandom);
      stb = 1'b1;
      tick();
      stb = 1'b0;
      tick();
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (lut_theta !== 8'd0 || sample_out !== '0) begin
         errors++;
         $display("FAIL async_rst_data: got theta=%0d out=%0h expected 0 0", lut_theta, sample_out);
      end
      checks++;
      if ({sample_valid, busy, overrun} !== 3'b000) begin
         errors++;
         $display("FAIL async_rst_flags: got %b expected 000", {sample_valid, busy, overrun});
      end
      model_acc = 0;
      exp_out = '0;
      tick();
      rst_n = 1'b1;
      tick();
      f2 = AW'($urandom);
      do_scan(f2, '0, 1'b0);
`ifdef SINE_PWM_SCHED_ROUND_EN
      exp0 = (int'(f2[15:8]) + int'(f2[7])) % 256;
`else
      exp0 = int'(f2[15:8]);
`endif
      checks++;
      if (int'(sample_out[8:0]) != exp0) begin
         errors++;
         $display("FAIL async_rst_first_theta: got %0d expected %0d", sample_out[8:0], exp0);
      end
   endtask

   task automatic test_round();
      int exp0;
`ifdef SINE_PWM_SCHED_ROUND_EN
      exp0 = 1;
`else
      exp0 = 0;
`endif
      clear_acc();
      do_scan(16'h0080, '0, 1'b0);
      checks++;
      if (int'(sample_out[8:0]) != exp0) begin
         errors++;
         $display("FAIL round_ch0: got %0d expected %0d", sample_out[8:0], exp0);
      end
   endtask

   task automatic test_random();
      bit prev_chain;
      bit chain;
      prev_chain = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (!prev_chain && ($urandom % 5 == 0)) clear_acc();
         chain = (i < 24) && ($urandom % 2 == 1);
         do_scan(AW'($urandom), (8*N)'($urandom), chain);
         if (!chain) begin
            for (int g = 0; g < int'($urandom % 4); g++) tick();
         end
         prev_chain = chain;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish within time budget");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_overrun();
      test_abort();
      test_back_to_back();
      test_async_reset();
      test_round();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
